// File: rtl/sample_rom_arbiter.sv
// sample_rom_arbiter
// Shares one synchronous sample ROM between the four drum voices
// (0 kick, 1 snare, 2 hat, 3 clap). One voice is granted per cycle. The
// returned byte comes back with a one-hot owner tag, ROM_LAT+1 cycles after
// its grant.
//
// Build option: define KICK_PRIO_EN to give the kick voice absolute priority.
// The snare, hat and clap voices then share a 3-way round-robin. When the
// macro is undefined, all four voices share a 4-way round-robin.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   en                 play enable; 0 blocks new grants
//   req[3:0]           per-voice read request
//   addr0..addr3       per-voice sample address
//   gnt[3:0]           one-hot grant (combinational)
//   rom_rd, rom_addr   ROM read strobe and address
//   rom_data           ROM read data, valid ROM_LAT cycles after rom_rd
//   rdata, rvalid      registered returned word and its one-hot owner
module sample_rom_arbiter #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [3:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    output logic [3:0]        gnt,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] rdata,
    output logic [3:0]        rvalid
);

    logic       found;
    logic [1:0] gnt_idx;
    logic [1:0] idx;

`ifdef KICK_PRIO_EN
    // Position 0..2 over voices 1..3.
    logic [1:0] kptr;
    logic [2:0] pos;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        pos     = '0;
        if (en && !reset) begin
            if (req[0]) begin
                found   = 1'b1;
                gnt_idx = 2'd0;
            end else begin
                for (int unsigned k = 0; k < 3; k++) begin
                    pos = {1'b0, kptr} + 3'(k);
                    if (pos >= 3'd3) pos = pos - 3'd3;
                    idx = pos[1:0] + 2'd1;
                    if (req[idx] && !found) begin
                        found   = 1'b1;
                        gnt_idx = idx;
                    end
                end
            end
        end
    end

    // Voice v sits at position v-1, so the next position is v mod 3.
    // A kick grant leaves the pointer untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            kptr <= '0;
        end else if (found && gnt_idx != 2'd0) begin
            kptr <= (gnt_idx == 2'd3) ? 2'd0 : gnt_idx;
        end
    end
`else
    logic [1:0] rr_ptr;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        if (en && !reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                idx = rr_ptr + 2'(i);
                if (req[idx] && !found) begin
                    found   = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
    end

    // The 2-bit add wraps 3 -> 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= gnt_idx + 2'd1;
        end
    end
`endif

    always_comb begin
        gnt      = '0;
        rom_addr = '0;
        if (found) begin
            gnt[gnt_idx] = 1'b1;
            case (gnt_idx)
                2'd0: rom_addr = addr0;
                2'd1: rom_addr = addr1;
                2'd2: rom_addr = addr2;
                2'd3: rom_addr = addr3;
            endcase
        end
    end

    assign rom_rd = found;

    // Each tag is {valid, one-hot id}. The rdata/rvalid register is the final
    // stage: the tag issued in cycle t reaches the last pipe slot in cycle
    // t+ROM_LAT, when rom_data holds that read's word.
    logic [4:0] tag_pipe [ROM_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ROM_LAT; i++) tag_pipe[i] <= '0;
            rdata  <= '0;
            rvalid <= '0;
        end else begin
            tag_pipe[0] <= {found, gnt};
            for (int unsigned i = 1; i < ROM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            if (tag_pipe[ROM_LAT-1][4]) begin
                rdata  <= rom_data;
                rvalid <= tag_pipe[ROM_LAT-1][3:0];
            end else begin
                rvalid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sample_rom_arbiter.sv
// tb_sample_rom_arbiter
// Directed bench for sample_rom_arbiter with ROM_LAT=2. A behavioural ROM
// returns rom_f(addr) two cycles after each read. When KICK_PRIO_EN is
// defined, the kick-priority scenarios run in place of the round-robin ones.
module tb_sample_rom_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [3:0]        req;
    logic [ADDR_W-1:0] addr0, addr1, addr2, addr3;
    logic [3:0]        gnt;
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] rdata;
    logic [3:0]        rvalid;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    sample_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(2)) dut (
        .clk(clk), .reset(reset), .en(en), .req(req),
        .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .gnt(gnt), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .rdata(rdata), .rvalid(rvalid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(logic [14:0] a);
        return a[7:0] ^ {a[14:8], 1'b1};
    endfunction

    // ROM with a two-cycle read latency.
    logic [ADDR_W-1:0] a_d1, a_d2;
    always_ff @(posedge clk) begin
        a_d1 <= rom_addr;
        a_d2 <= a_d1;
    end
    assign rom_data = rom_f(a_d2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge so that inputs can be driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; req = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    function automatic logic [7:0] voice_data(int v);
        case (v)
            0: return rom_f(addr0);
            1: return rom_f(addr1);
            2: return rom_f(addr2);
            default: return rom_f(addr3);
        endcase
    endfunction

    logic [3:0] exp_g, exp_v;

    initial begin
        reset = 1'b1; en = 1'b0; req = '0;
        addr0 = 15'h0010; addr1 = 15'h0221; addr2 = 15'h1432; addr3 = 15'h7FF3;
        tick();
        settle();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_rom_addr", 32'(rom_addr), 32'h0);
        tick();
        reset = 1'b0;

`ifdef KICK_PRIO_EN
        // Kick always wins while it requests.
        en = 1'b1; req = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            settle();
            check("kick_prio", 32'(gnt), 32'h1);
            tick();
        end
        // Without kick, the other three voices rotate starting from snare.
        req = 4'b1110;
        for (int c = 0; c < 4; c++) begin
            settle();
            exp_g = 4'b0010 << (c % 3);
            check("kick_rr", 32'(gnt), 32'(exp_g));
            tick();
        end
        // A kick grant does not move the 3-way pointer.
        req = 4'b1111; settle(); check("kick_mid", 32'(gnt), 32'h1); tick();
        req = 4'b1110; settle(); check("kick_resume", 32'(gnt), 32'h4); tick();
        req = '0;
`else
        // Single voice read.
        addr2 = 15'h0123;
        en = 1'b1; req = 4'b0100;
        settle();
        check("single_gnt", 32'(gnt), 32'h4);
        check("single_rd", 32'(rom_rd), 32'h1);
        check("single_addr", 32'(rom_addr), 32'h0123);
        tick(); req = '0;
        for (int c = 1; c <= 4; c++) begin
            settle();
            if (c == 3) begin
                check("single_rvalid", 32'(rvalid), 32'h4);
                check("single_rdata", 32'(rdata), 32'h20);
            end else begin
                check("single_rvalid_idle", 32'(rvalid), 32'h0);
            end
            if (c == 4) check("single_rdata_hold", 32'(rdata), 32'h20);
            tick();
        end
        addr2 = 15'h1432;

        // Full contention.
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req = (c < 8) ? 4'b1111 : 4'b0000;
            settle();
            exp_g = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            check("rr_gnt", 32'(gnt), 32'(exp_g));
            exp_v = (c >= 3 && c < 11) ? (4'b0001 << ((c - 3) % 4)) : 4'b0000;
            check("rr_rvalid", 32'(rvalid), 32'(exp_v));
            if (exp_v != 4'b0000) check("rr_rdata", 32'(rdata), 32'(voice_data((c - 3) % 4)));
            tick();
        end

        // Pointer fairness: after voice 2 is granted, the pointer is 3 and wraps to 0.
        do_reset();
        en = 1'b1; req = 4'b0100;
        settle(); check("fair_g2", 32'(gnt), 32'h4); tick();
        req = 4'b0101;
        settle(); check("fair_wrap", 32'(gnt), 32'h1); tick();
        settle(); check("fair_next", 32'(gnt), 32'h4); tick();
        req = '0;

        // en gating.
        do_reset();
        tick(); tick(); tick();
        en = 1'b1; req = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            en = (c < 2 || c == 6) ? 1'b1 : 1'b0;
            settle();
            case (c)
                0: exp_g = 4'b0001;
                1: exp_g = 4'b0010;
                6: exp_g = 4'b0100;
                default: exp_g = 4'b0000;
            endcase
            check("en_gnt", 32'(gnt), 32'(exp_g));
            exp_v = (c == 3) ? 4'b0001 : (c == 4) ? 4'b0010 : 4'b0000;
            check("en_rvalid", 32'(rvalid), 32'(exp_v));
            tick();
        end
        req = '0; en = 1'b0;

        // Reset mid-flight.
        do_reset();
        tick(); tick(); tick();
        en = 1'b1; req = 4'b0010;
        settle(); check("rmf_gnt", 32'(gnt), 32'h2); tick();
        reset = 1'b1; req = '0;
        settle(); check("rmf_rvalid1", 32'(rvalid), 32'h0); tick();
        reset = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            settle();
            check("rmf_rvalid", 32'(rvalid), 32'h0);
            tick();
        end
        // If the pointer had not been reset it would be 2 and voice 3 would win.
        req = 4'b1001;
        settle(); check("rmf_ptr", 32'(gnt), 32'h1); tick();
        req = '0;
`endif
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
